clk_freq_meter: RTL and testbench

// - Measures frequency of up to NUM_CH clock outputs (for example PLL clk_o[3:0]) against the system clock clk_i.
// - Each input is sampled as data and its rising edges are counted over a fixed gate window.
// - Counts are reported through a valid/ready handshake.
// - Sits downstream of the PLL for bring-up, lock sanity checks and built-in self-test.

---
 rtl/clk_freq_meter_pkg.sv | 18 +
 rtl/clk_edge_sync.sv | 27 ++
 rtl/clk_freq_meter.sv | 145 ++++++++++++++
 tb/tb_clk_freq_meter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_freq_meter_pkg.sv
// Shared types and constants for the clock frequency meter.
// The optional limit checker is enabled with the CLK_FREQ_METER_LIMITS_EN macro (see clk_freq_meter).
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must hold values 0..cycles-1.
  function automatic int gate_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// One measured clock sampled as data: SYNC_STAGES-deep synchronizer plus a history
// flop; edge_o pulses for one clk_i cycle per detected rising edge.
module clk_edge_sync
  import clk_freq_meter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic meas_clk_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of NUM_CH asynchronous clocks over a GATE_CYCLES window of clk_i.
// Define CLK_FREQ_METER_LIMITS_EN to add per-channel lo/hi limit checking (in_range_o).
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int CONTINUOUS  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       meas_clk_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic                    overrun_o,
`ifdef CLK_FREQ_METER_LIMITS_EN
  input  logic [NUM_CH*CNT_W-1:0] lo_lim_i,
  input  logic [NUM_CH*CNT_W-1:0] hi_lim_i,
  output logic [NUM_CH-1:0]       in_range_o,
`endif
  output logic [1:0]              state_o
);

  localparam int              GW        = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit              CONT      = (CONTINUOUS != 0);

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_inc [NUM_CH];
  logic [NUM_CH-1:0] edge_w;
  logic             gate_last;
  logic             clr_cnt;
  logic             run_cnt;
  logic             capture;
  logic             ovr_set;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
    clk_edge_sync u_sync (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .meas_clk_i (meas_clk_i[k]),
      .edge_o     (edge_w[k])
    );
  end

  assign gate_last = (gate_q == GATE_LAST);

  // Saturating next count; also the value captured on the last gate cycle,
  // so an edge landing on that cycle is included.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_inc[k] = (edge_w[k] && (cnt_q[k] != CNT_MAX)) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
    end
  end

  // valid_o/ready_i: a result transfers on any cycle where both are high;
  // until then valid_o stays high and count_o stays fixed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    run_cnt = 1'b0;
    capture = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        clr_cnt = 1'b1;
        if (start_i || CONT) state_d = MEASURE;
      end
      MEASURE: begin
        run_cnt = 1'b1;
        if (gate_last) begin
          capture = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (ready_i) begin
          clr_cnt = 1'b1;
          state_d = CONT ? MEASURE : IDLE;
        end else if (CONT) begin
          // Background window; a completed one here is a dropped result.
          run_cnt = 1'b1;
          ovr_set = gate_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gate_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (clr_cnt || (run_cnt && gate_last)) begin
      gate_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (run_cnt) begin
      gate_q <= gate_q + GW'(1);
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_inc[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o   <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (capture) begin
        for (int k = 0; k < NUM_CH; k++) count_o[k*CNT_W +: CNT_W] <= cnt_inc[k];
      end
      if (ovr_set)      overrun_o <= 1'b1;
      else if (start_i) overrun_o <= 1'b0;
    end
  end

`ifdef CLK_FREQ_METER_LIMITS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_range_o <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_CH; k++) begin
        in_range_o[k] <= (cnt_inc[k] >= lo_lim_i[k*CNT_W +: CNT_W]) &&
                         (cnt_inc[k] <= hi_lim_i[k*CNT_W +: CNT_W]);
      end
    end
  end
`endif

  assign valid_o = (state_q == REPORT);
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: three instances (normal, 8-bit saturating, continuous)
// share the measured clocks; expected counts come from a log of driven rising edges.
`timescale 1ns/1ps
module tb_clk_freq_meter;
  import clk_freq_meter_pkg::*;

  localparam int NUM_CH = 4;
  localparam int GATE   = 1000;
  localparam int CW     = 16;
  localparam int CW_S   = 8;
  localparam int MAXCYC = 65536;
  localparam int SAT16  = 65535;
  localparam int SAT8   = 255;

  // clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [NUM_CH-1:0] meas_clk;
  logic start_i = 1'b0, ready_i = 1'b0, start_c = 1'b0, ready_c = 1'b0;

  logic busy, valid, overrun;       logic [NUM_CH*CW-1:0]   count;   logic [1:0] state;
  logic busy_s, valid_s, overrun_s; logic [NUM_CH*CW_S-1:0] count_s; logic [1:0] state_s;
  logic busy_c, valid_c, overrun_c; logic [NUM_CH*CW-1:0]   count_c; logic [1:0] state_c;
`ifdef CLK_FREQ_METER_LIMITS_EN
  logic [NUM_CH*CW-1:0]   lo_lim = '0, hi_lim = '1;
  logic [NUM_CH*CW_S-1:0] lo_s = '0, hi_s = '1;
  logic [NUM_CH-1:0]      in_range, in_range_s, in_range_c;
`endif

  clk_freq_meter #(.NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .CNT_W(CW), .CONTINUOUS(0)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .meas_clk_i(meas_clk), .start_i(start_i),
    .busy_o(busy), .valid_o(valid), .ready_i(ready_i), .count_o(count), .overrun_o(overrun),
`ifdef CLK_FREQ_METER_LIMITS_EN
    .lo_lim_i(lo_lim), .hi_lim_i(hi_lim), .in_range_o(in_range),
`endif
    .state_o(state));

  clk_freq_meter #(.NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .CNT_W(CW_S), .CONTINUOUS(0)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .meas_clk_i(meas_clk), .start_i(start_i),
    .busy_o(busy_s), .valid_o(valid_s), .ready_i(ready_i), .count_o(count_s), .overrun_o(overrun_s),
`ifdef CLK_FREQ_METER_LIMITS_EN
    .lo_lim_i(lo_s), .hi_lim_i(hi_s), .in_range_o(in_range_s),
`endif
    .state_o(state_s));

  clk_freq_meter #(.NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .CNT_W(CW), .CONTINUOUS(1)) u_cont (
    .clk_i(clk_i), .rst_ni(rst_ni), .meas_clk_i(meas_clk), .start_i(start_c),
    .busy_o(busy_c), .valid_o(valid_c), .ready_i(ready_c), .count_o(count_c), .overrun_o(overrun_c),
`ifdef CLK_FREQ_METER_LIMITS_EN
    .lo_lim_i(lo_lim), .hi_lim_i(hi_lim), .in_range_o(in_range_c),
`endif
    .state_o(state_c));

  // measured clocks: driven at negedge, half period in clk_i cycles; each rise is
  // logged against the clk_i posedge that first samples it
  int half [NUM_CH];
  int ph   [NUM_CH];
  bit rise_at [NUM_CH][MAXCYC];

  initial begin
    meas_clk = '0;
    for (int k = 0; k < NUM_CH; k++) ph[k] = 0;
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < NUM_CH; k++) begin
        if (ph[k] <= 1) begin
          ph[k] = half[k];
          meas_clk[k] = ~meas_clk[k];
          if (meas_clk[k] && (cyc + 1 < MAXCYC)) rise_at[k][cyc + 1] = 1'b1;
        end else begin
          ph[k] = ph[k] - 1;
        end
      end
    end
  end

  // reference model: edges sampled between start-1 and start+GATE-2 (3-cycle detect latency)
  function automatic int raw_cnt(input int k, input int p0);
    int n = 0;
    for (int s = p0 - 1; s <= p0 + GATE - 2; s++)
      if (s >= 0 && s < MAXCYC && rise_at[k][s]) n++;
    return n;
  endfunction

  // scoreboard
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp, input int tol = 0);
    longint d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    else n_pass++;
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse_start(output int p0);
    @(negedge clk_i);
    start_i = 1'b1;
    p0 = cyc + 1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input int p0, input string tag);
    bit seen = 1'b0;
    int t = 0;
    for (int i = 0; i < 3 * GATE && !seen; i++) begin
      if (valid) begin seen = 1'b1; t = cyc; end
      else @(negedge clk_i);
    end
    chk({tag, "_valid_seen"}, seen, 1);
    chk({tag, "_latency"}, t, p0 + GATE);
  endtask

  task automatic check_counts(input int p0, input string tag, input int tol);
    int r;
    for (int k = 0; k < NUM_CH; k++) begin
      r = raw_cnt(k, p0);
      chk($sformatf("%s_cnt%0d", tag, k), count[k*CW +: CW], (r > SAT16) ? SAT16 : r, tol);
      chk($sformatf("%s_sat%0d", tag, k), count_s[k*CW_S +: CW_S],
          (r > SAT8) ? SAT8 : r, (r > SAT8) ? 0 : tol);
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk_i);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk({tag, "_valid_drop"}, valid, 0);
    chk({tag, "_state_idle"}, state, IDLE);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  int p0, p0c, drops, stray;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

  initial begin
    half[0] = 2; half[1] = 1; half[2] = 5; half[3] = 10;   // 25/50/10/5 MHz

    // reset state
    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", state, IDLE);
    chk("rst_cont_valid", valid_c, 0);
    rst_ni = 1'b1;
    p0c = cyc + 1;
    tick(4);

    // single measurement, then hold ready low
    pulse_start(p0);
    chk("s1_busy", busy, 1);
    wait_valid(p0, "s1");
    check_counts(p0, "s1", 1);
    chk("s1_state", state, REPORT);
    drops = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (!valid) drops++;
      if (i == 250) start_i = 1'b1;     // ignored while busy
      if (i == 251) start_i = 1'b0;
    end
    chk("s2_valid_held", drops, 0);
    check_counts(p0, "s2", 1);
    handshake("s2");

    // continuous: two windows without a handshake
    while (cyc < p0c + 2 * GATE + 4) @(negedge clk_i);
    chk("s4_overrun", overrun_c, 1);
    chk("s4_valid", valid_c, 1);
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("s4_first_cnt%0d", k), count_c[k*CW +: CW], raw_cnt(k, p0c), 1);
    @(negedge clk_i); start_c = 1'b1;
    @(negedge clk_i); start_c = 1'b0;
    chk("s4_overrun_clr", overrun_c, 0);
    ready_c = 1'b1;
    @(negedge clk_i);
    chk("s4_valid_drop", valid_c, 0);
    chk("s4_rearm", state_c, MEASURE);

    // randomized clocks and ready behaviour
    for (int it = 0; it < 6; it++) begin
      @(negedge clk_i);
      for (int k = 0; k < NUM_CH; k++) half[k] = $urandom_range(1, 12);
      ready_i = 1'($urandom_range(0, 1));
      tick($urandom_range(3, 20));
      pulse_start(p0);
      wait_valid(p0, $sformatf("r%0d", it));
      check_counts(p0, $sformatf("r%0d", it), 1);
      tick($urandom_range(0, 15));
      handshake($sformatf("r%0d", it));
    end

    // start on the last gate cycle is ignored
    half[0] = 2; half[1] = 1; half[2] = 5; half[3] = 10;
    tick(20);
    pulse_start(p0);
    while (cyc < p0 + GATE - 1) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("last_valid", valid, 1);
    handshake("last");
    tick(3);
    chk("last_start_ignored", busy, 0);

    // reset mid-window
    pulse_start(p0);
    while (cyc < p0 + 500) @(negedge clk_i);
    rst_ni = 1'b0;
    tick(2);
    chk("s5_rst_count", count, 0);
    chk("s5_rst_valid", valid, 0);
    rst_ni = 1'b1;
    stray = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk_i);
      if (valid) stray++;
    end
    chk("s5_no_stale_valid", stray, 0);
`ifdef CLK_FREQ_METER_LIMITS_EN
    for (int k = 0; k < NUM_CH; k++) begin
      lo_lim[k*CW +: CW] = 16'd240;
      hi_lim[k*CW +: CW] = 16'd260;
    end
`endif
    pulse_start(p0);
    wait_valid(p0, "s5");
    check_counts(p0, "s5", 0);
`ifdef CLK_FREQ_METER_LIMITS_EN
    chk("s6_in_range", in_range, 4'b0001);
`endif
    handshake("s5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
